// File: rtl/i2c_pkg.sv
// rtl/i2c_pkg.sv - shared state encodings, defaults and helpers for the I2C request arbiter
package i2c_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_LAUNCH   = 2'd1;
  localparam logic [1:0] ST_WAIT     = 2'd2;
  localparam logic [1:0] ST_COMPLETE = 2'd3;

  localparam logic [15:0] TIMEOUT_DEFAULT = 16'd50000;

  typedef struct packed {
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
  } txn_t;

  // Round robin: on a tie the pointer decides, otherwise whoever is asking wins.
  function automatic logic pick_winner(input logic req0, input logic req1, input logic ptr);
    return (req0 && req1) ? ptr : req1;
  endfunction

endpackage

// File: rtl/i2c_request_arbiter_if.sv
// rtl/i2c_request_arbiter_if.sv - requester and I2C master signals of the arbiter
interface i2c_request_arbiter_if;
  logic       Req0, Req1;
  logic [6:0] Addr0, Addr1;
  logic       RW0, RW1;
  logic [7:0] WrData0, WrData1;
  logic       Grant0, Grant1;
  logic       Done0, Done1;
  logic       Error;
  logic [7:0] RdData;
  logic       MasterGo, MasterAbort;
  logic [6:0] MasterAddr;
  logic       MasterReadorWrite;
  logic [7:0] MasterWrData;
  logic       MasterDone, MasterAckError;
  logic [7:0] MasterRdData;

  // Arbiter side.
  modport slave (
    input  Req0, Req1, Addr0, Addr1, RW0, RW1, WrData0, WrData1,
    input  MasterDone, MasterAckError, MasterRdData,
    output Grant0, Grant1, Done0, Done1, Error, RdData,
    output MasterGo, MasterAbort, MasterAddr, MasterReadorWrite, MasterWrData
  );

  // Environment side: requesters plus the I2C master.
  modport master (
    output Req0, Req1, Addr0, Addr1, RW0, RW1, WrData0, WrData1,
    output MasterDone, MasterAckError, MasterRdData,
    input  Grant0, Grant1, Done0, Done1, Error, RdData,
    input  MasterGo, MasterAbort, MasterAddr, MasterReadorWrite, MasterWrData
  );
endinterface

// File: rtl/arb_watchdog.sv
// rtl/arb_watchdog.sv - saturating 16-bit wait watchdog for the arbiter
module arb_watchdog
  import i2c_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input  logic clock,
  input  logic Reset,
  input  logic Clear,
  input  logic Enable,
  output logic Expired
);

  logic [15:0] count;

  // Count enabled cycles, saturating at all-ones so it can never wrap back to zero.
  always_ff @(posedge clock) begin
    if (Reset || Clear) begin
      count <= 16'd0;
    end else if (Enable && (count != 16'hFFFF)) begin
      count <= count + 16'd1;
    end
  end

  assign Expired = (count == (TIMEOUT_CYCLES - 16'd1));

endmodule

// File: rtl/i2c_request_arbiter.sv
// rtl/i2c_request_arbiter.sv - two-requester round-robin arbiter in front of an I2C master
module i2c_request_arbiter
  import i2c_pkg::*;
#(
  parameter logic [15:0] TIMEOUT_CYCLES = TIMEOUT_DEFAULT
) (
  input logic                   clock,
  input logic                   Reset,
  i2c_request_arbiter_if.slave  bus
);

  logic [1:0] state;
  logic       ptr;
  logic       owner;
  logic       winner;
  logic       expired;
  txn_t       sel;

  assign winner = pick_winner(bus.Req0, bus.Req1, ptr);
  assign sel    = winner ? {bus.Addr1, bus.RW1, bus.WrData1}
                         : {bus.Addr0, bus.RW0, bus.WrData0};

  arb_watchdog #(.TIMEOUT_CYCLES(TIMEOUT_CYCLES)) u_watchdog (
    .clock   (clock),
    .Reset   (Reset),
    .Clear   (state == ST_LAUNCH),
    .Enable  (state == ST_WAIT),
    .Expired (expired)
  );

  // Arbitration FSM; every output is a register set on the edge entering the state it belongs to.
  always_ff @(posedge clock) begin
    if (Reset) begin
      state                 <= ST_IDLE;
      ptr                   <= 1'b0;
      owner                 <= 1'b0;
      bus.Grant0            <= 1'b0;
      bus.Grant1            <= 1'b0;
      bus.Done0             <= 1'b0;
      bus.Done1             <= 1'b0;
      bus.Error             <= 1'b0;
      bus.RdData            <= 8'h00;
      bus.MasterGo          <= 1'b0;
      bus.MasterAbort       <= 1'b0;
      bus.MasterAddr        <= 7'h00;
      bus.MasterReadorWrite <= 1'b0;
      bus.MasterWrData      <= 8'h00;
    end else begin
      bus.MasterGo    <= 1'b0;
      bus.MasterAbort <= 1'b0;
      bus.Done0       <= 1'b0;
      bus.Done1       <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (bus.Req0 || bus.Req1) begin
            state                 <= ST_LAUNCH;
            owner                 <= winner;
            bus.Grant0            <= ~winner;
            bus.Grant1            <= winner;
            bus.MasterGo          <= 1'b1;
            bus.MasterAddr        <= sel.addr;
            bus.MasterReadorWrite <= sel.rw;
            bus.MasterWrData      <= sel.wdata;
          end
        end
        ST_LAUNCH: begin
          state <= ST_WAIT;
        end
        ST_WAIT: begin
          // A master completion in the expiry cycle takes precedence over the abort.
          if (bus.MasterDone) begin
            state      <= ST_COMPLETE;
            bus.RdData <= bus.MasterRdData;
            bus.Error  <= bus.MasterAckError;
            bus.Done0  <= ~owner;
            bus.Done1  <= owner;
          end else if (expired) begin
            state           <= ST_COMPLETE;
            bus.MasterAbort <= 1'b1;
            bus.RdData      <= 8'h00;
            bus.Error       <= 1'b1;
            bus.Done0       <= ~owner;
            bus.Done1       <= owner;
          end
        end
        default: begin
          state      <= ST_IDLE;
          ptr        <= ~owner;
          bus.Grant0 <= 1'b0;
          bus.Grant1 <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_i2c_request_arbiter.sv
// tb/tb_i2c_request_arbiter.sv - scoreboard bench for the I2C request arbiter
module tb_i2c_request_arbiter;

  typedef struct {
    int         id;
    logic [6:0] addr;
    logic       rw;
    logic [7:0] wdata;
    logic [7:0] rdata;
    logic       ack;
    int         delay;
    bit         scramble;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  logic clock = 1'b0;
  logic Reset = 1'b1;

  i2c_request_arbiter_if bus();

  i2c_request_arbiter #(.TIMEOUT_CYCLES(16'd16)) dut (
    .clock (clock),
    .Reset (Reset),
    .bus   (bus.slave)
  );

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
    check("grant_overlap", 32'(bus.Grant0 & bus.Grant1), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_grant0"}, 32'(bus.Grant0), 32'd0);
    check({tag, "_grant1"}, 32'(bus.Grant1), 32'd0);
    check({tag, "_done0"}, 32'(bus.Done0), 32'd0);
    check({tag, "_done1"}, 32'(bus.Done1), 32'd0);
    check({tag, "_error"}, 32'(bus.Error), 32'd0);
    check({tag, "_rddata"}, 32'(bus.RdData), 32'd0);
    check({tag, "_go"}, 32'(bus.MasterGo), 32'd0);
    check({tag, "_abort"}, 32'(bus.MasterAbort), 32'd0);
    check({tag, "_maddr"}, 32'(bus.MasterAddr), 32'd0);
    check({tag, "_mrw"}, 32'(bus.MasterReadorWrite), 32'd0);
    check({tag, "_mwdata"}, 32'(bus.MasterWrData), 32'd0);
  endtask

  task automatic set_req(input int id, input logic [6:0] addr, input logic rw, input logic [7:0] wdata);
    if (id == 0) begin
      bus.Addr0 = addr; bus.RW0 = rw; bus.WrData0 = wdata; bus.Req0 = 1'b1;
    end else begin
      bus.Addr1 = addr; bus.RW1 = rw; bus.WrData1 = wdata; bus.Req1 = 1'b1;
    end
  endtask

  task automatic push(input int id, input logic [6:0] addr, input logic rw, input logic [7:0] wdata,
                      input logic [7:0] rdata, input logic ack, input int delay, input bit scramble);
    exp_t e;
    e.id = id; e.addr = addr; e.rw = rw; e.wdata = wdata;
    e.rdata = rdata; e.ack = ack; e.delay = delay; e.scramble = scramble;
    sb.push_back(e);
  endtask

  // Plays the I2C master for the oldest expected transaction and checks the arbiter around it.
  task automatic serve();
    exp_t e;
    int   n;
    int   lat;
    bit   abort;
    e = sb.pop_front();
    abort = (e.delay < 0);
    n = 0;
    while (!bus.MasterGo && n < 20) begin
      tick();
      n++;
    end
    check("go_seen", 32'(bus.MasterGo), 32'd1);
    if (!bus.MasterGo) return;
    check("go_grant0", 32'(bus.Grant0), 32'(e.id == 0));
    check("go_grant1", 32'(bus.Grant1), 32'(e.id == 1));
    check("go_addr", 32'(bus.MasterAddr), 32'(e.addr));
    check("go_rw", 32'(bus.MasterReadorWrite), 32'(e.rw));
    check("go_wdata", 32'(bus.MasterWrData), 32'(e.wdata));
    if (e.scramble) begin
      bus.Req0 = 1'b0; bus.Addr0 = 7'h7F; bus.RW0 = 1'b1; bus.WrData0 = 8'hFF;
    end
    bus.MasterRdData   = e.rdata;
    bus.MasterAckError = e.ack;
    lat = 1;
    tick();
    check("go_one_cycle", 32'(bus.MasterGo), 32'd0);
    if (!abort) begin
      while (lat < e.delay) begin
        tick();
        lat++;
      end
      bus.MasterDone = 1'b1;
      tick();
      lat++;
      bus.MasterDone = 1'b0;
    end
    while (!(bus.Done0 || bus.Done1) && lat < 40) begin
      tick();
      lat++;
    end
    check("latency", 32'(lat), abort ? 32'd17 : 32'(e.delay + 1));
    check("done0", 32'(bus.Done0), 32'(e.id == 0));
    check("done1", 32'(bus.Done1), 32'(e.id == 1));
    check("error", 32'(bus.Error), abort ? 32'd1 : 32'(e.ack));
    check("rddata", 32'(bus.RdData), abort ? 32'd0 : 32'(e.rdata));
    check("abort", 32'(bus.MasterAbort), 32'(abort));
    check("hold_grant", 32'({bus.Grant1, bus.Grant0}), (e.id == 1) ? 32'd2 : 32'd1);
    check("hold_addr", 32'(bus.MasterAddr), 32'(e.addr));
    check("hold_rw", 32'(bus.MasterReadorWrite), 32'(e.rw));
    check("hold_wdata", 32'(bus.MasterWrData), 32'(e.wdata));
    tick();
    check("done_pulse", 32'({bus.Done1, bus.Done0}), 32'd0);
    check("abort_pulse", 32'(bus.MasterAbort), 32'd0);
    check("grant_drop", 32'({bus.Grant1, bus.Grant0}), 32'd0);
  endtask

  initial begin
    bus.Req0 = 1'b0; bus.Req1 = 1'b0;
    bus.Addr0 = 7'h00; bus.Addr1 = 7'h00;
    bus.RW0 = 1'b0; bus.RW1 = 1'b0;
    bus.WrData0 = 8'h00; bus.WrData1 = 8'h00;
    bus.MasterDone = 1'b0; bus.MasterAckError = 1'b0; bus.MasterRdData = 8'h00;
    Reset = 1'b1;
    tick();
    tick();
    check_zero("reset");
    Reset = 1'b0;
    tick();

    // Stray master completion while idle.
    bus.MasterDone = 1'b1; bus.MasterRdData = 8'hEE; bus.MasterAckError = 1'b1;
    tick();
    bus.MasterDone = 1'b0;
    tick();
    check_zero("stray_done");

    // Single write on requester 0, inputs disturbed and Req dropped mid-transaction.
    set_req(0, 7'h48, 1'b0, 8'hA5);
    push(0, 7'h48, 1'b0, 8'hA5, 8'h00, 1'b0, 3, 1'b1);
    serve();

    // Simultaneous requests after reset: 0,1,0,1.
    Reset = 1'b1;
    tick();
    Reset = 1'b0;
    tick();
    set_req(0, 7'h10, 1'b0, 8'h11);
    set_req(1, 7'h21, 1'b1, 8'h22);
    push(0, 7'h10, 1'b0, 8'h11, 8'hB0, 1'b0, 2, 1'b0);
    push(1, 7'h21, 1'b1, 8'h22, 8'hB1, 1'b0, 2, 1'b0);
    push(0, 7'h10, 1'b0, 8'h11, 8'hB2, 1'b1, 2, 1'b0);
    push(1, 7'h21, 1'b1, 8'h22, 8'hB3, 1'b0, 2, 1'b0);
    serve();
    serve();
    serve();
    bus.Req0 = 1'b0;
    serve();
    bus.Req1 = 1'b0;

    // Read on requester 1 with an ack error.
    set_req(1, 7'h50, 1'b1, 8'h00);
    push(1, 7'h50, 1'b1, 8'h00, 8'h3C, 1'b1, 3, 1'b0);
    serve();
    bus.Req1 = 1'b0;

    // Watchdog expiry with no master completion.
    set_req(0, 7'h48, 1'b0, 8'h5A);
    push(0, 7'h48, 1'b0, 8'h5A, 8'h99, 1'b0, -1, 1'b0);
    serve();
    bus.Req0 = 1'b0;

    // Master completion on the expiry cycle.
    set_req(0, 7'h12, 1'b0, 8'hC3);
    push(0, 7'h12, 1'b0, 8'hC3, 8'h77, 1'b0, 16, 1'b0);
    serve();
    bus.Req0 = 1'b0;

    // Reset in WAIT, then a fresh request on requester 1.
    set_req(1, 7'h5A, 1'b1, 8'h00);
    begin
      int n;
      n = 0;
      while (!bus.MasterGo && n < 20) begin
        tick();
        n++;
      end
      check("rst_go_seen", 32'(bus.MasterGo), 32'd1);
    end
    tick();
    tick();
    tick();
    Reset = 1'b1;
    bus.Req1 = 1'b0;
    tick();
    check_zero("mid_reset");
    Reset = 1'b0;
    tick();
    set_req(1, 7'h33, 1'b0, 8'h44);
    push(1, 7'h33, 1'b0, 8'h44, 8'h55, 1'b0, 3, 1'b0);
    serve();
    bus.Req1 = 1'b0;
    tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
